calc_entry_fsm: RTL
===================

Name: calc_entry_fsm

Overview:
- Sits directly downstream of the keypad scanner. Consumes its decoded key strobes: btn_press, is_num, is_op, is_eq, num_val and op_val.
- Turns key presses into calculator operations: builds operand A, latches an operator, builds operand B, then computes and holds the result.
- Drives the value and flags that the display stage shows.
- Supports operator chaining, e.g. 2+3+4=.

Parameters:
- NDIG, 4, maximum decimal digits per operand; MAXV = 10^NDIG - 1.
- VAL_W, 14, magnitude width in bits; must satisfy 2^VAL_W > MAXV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- btn_press  in  1  high while a key is held or for its hold-off window; one press gives one contiguous high run
- is_num  in  1  key is a digit; valid while btn_press=1
- is_op  in  1  key is an operator; valid while btn_press=1
- is_eq  in  1  key is equals; valid while btn_press=1
- num_val  in  4  digit value 0..9
- op_val  in  2  1=add, 2=sub, 3=mul, 0=none
- disp_mag  out  VAL_W  magnitude to display
- disp_neg  out  1  sign of the displayed value
- err  out  1  overflow flag
- state  out  3  current FSM state (debug)
- op_pending  out  2  latched operator
- evt_ack  out  1  one-cycle pulse per accepted key event

Behaviour:
- Reset (rst=0, async): state=S_A; A=0; B=0; op=0; digit counters=0; btn_press_q=0; all outputs 0.
- Event detection:
  - evt = btn_press & ~btn_press_q, with btn_press_q registered.
  - is_num, is_op, is_eq, num_val and op_val are sampled in the evt cycle only.
  - A held key produces exactly one event.
  - If several of is_num/is_op/is_eq are high together, priority is num > op > eq.
- Latency: all register updates happen on the clock edge that ends the evt cycle; outputs are visible the next cycle. evt_ack is high in that same next cycle, but only for accepted events. Ignored events give no ack.
- A is signed (VAL_W+1 bits) to hold chained negative results. B is unsigned (VAL_W bits).
- Digit append: X = X*10 + num_val and cnt++, only when cnt < NDIG. Otherwise the digit is ignored (no ack).
- S_A (entering A):
  - num: append to A.
  - op: op = op_val, go to S_OP.
  - eq: ignored.
- S_OP (operator latched):
  - num: B = num_val, cntB = 1, go to S_B.
  - op: replace op (ack).
  - eq: ignored.
- S_B (entering B):
  - num: append to B.
  - op: A = alu(A, op, B); on overflow go to S_ERR, else latch the new op and go to S_OP.
  - eq: A = alu(A, op, B); on overflow go to S_ERR, else go to S_RES.
- S_RES (result held):
  - num: A = num_val, cntA = 1, go to S_A.
  - op: keep A as the chained operand, latch op, go to S_OP.
  - eq: ignored.
- S_ERR (err=1, displays 0):
  - num: clear, A = num_val, go to S_A.
  - op or eq: clear to S_A with A=0.
- After any exit to S_A, B and the counters are cleared.
- ALU:
  - Computed in signed 2*VAL_W+2 bits; mul is a full product.
  - Overflow when |result| > MAXV.
  - op=0 with an eq event passes A through unchanged.
- Display mapping:
  - S_A / S_RES: |A| and sign(A).
  - S_OP: |A| and sign(A).
  - S_B: B, with disp_neg=0.
  - A value of 0 always shows disp_neg=0.
- op_pending is 0 in S_A, S_RES and S_ERR.

Decomposition:
- Package calc_pkg:
  - OP_NONE/ADD/SUB/MUL encodings, matching the scanner's op_val.
  - State encodings S_A=0, S_OP=1, S_B=2, S_RES=3, S_ERR=4.
  - Constant MAXV.
- One sub-module, calc_alu: combinational (a, b, op) -> result and ovf. The FSM and event detector stay in the top level.

Test Plan:
- Key events 1, 2, +, 3, = (each btn_press high for 5 cycles) -> disp_mag=15, disp_neg=0, state=S_RES, 5 evt_ack pulses.
- 5, -, 8, = -> disp_mag=3, disp_neg=1; then + 4 = -> disp_mag=1, disp_neg=0.
- Digits 1, 2, 3, 4, 5 -> disp_mag=1234; the fifth digit gives no evt_ack.
- 9999 * 9999 = -> err=1, state=S_ERR, disp_mag=0; then key 7 -> err=0, disp_mag=7, state=S_A.
- 2 + 3 + (disp_mag=5, op_pending=1) then 4 = -> disp_mag=9; + then - in S_OP -> op_pending=2.
- btn_press held 20 cycles with num_val=6 -> exactly one append.
- rst pulled low mid-entry, between clock edges -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings and constants for the calculator key-entry slice.
package calc_pkg;

  // Operator encodings, identical to the keypad scanner's op_val
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_e;

  // Entry FSM states; the numeric values are exported on the debug port
  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_OP  = 3'd1,
    S_B   = 3'd2,
    S_RES = 3'd3,
    S_ERR = 3'd4
  } state_e;

  // Largest magnitude representable with ndig decimal digits (10^ndig - 1)
  function automatic int calc_maxv(input int ndig);
    int v;
    v = 1;
    for (int i = 0; i < ndig; i++) v = v * 10;
    return v - 1;
  endfunction

  localparam int NDIG_DEF  = 4;
  localparam int VAL_W_DEF = 14;
  localparam int MAXV      = calc_maxv(NDIG_DEF);

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU: signed A op unsigned B with range check.
module calc_alu
  import calc_pkg::*;
#(
  parameter int VAL_W   = VAL_W_DEF,
  parameter int MAX_VAL = MAXV
) (
  input  logic signed [VAL_W:0]   i_a,
  input  logic        [VAL_W-1:0] i_b,
  input  op_e                     i_op,
  output logic signed [VAL_W:0]   o_result,
  output logic                    o_ovf
);

  // Wide enough that a full product of the operands never wraps
  localparam int W2 = 2 * VAL_W + 2;
  localparam logic [W2-1:0] MAX_W = W2'(MAX_VAL);

  logic signed [W2-1:0] w_a_ext;
  logic signed [W2-1:0] w_b_ext;
  logic signed [W2-1:0] w_wide;
  logic signed [W2-1:0] w_abs;

  assign w_a_ext = {{(W2 - VAL_W - 1){i_a[VAL_W]}}, i_a};
  assign w_b_ext = {{(W2 - VAL_W){1'b0}}, i_b};

  // Select the operation; no operator latched simply passes A through
  always_comb begin
    w_wide = w_a_ext;
    case (i_op)
      OP_ADD:  w_wide = w_a_ext + w_b_ext;
      OP_SUB:  w_wide = w_a_ext - w_b_ext;
      OP_MUL:  w_wide = w_a_ext * w_b_ext;
      default: w_wide = w_a_ext;
    endcase
  end

  // Overflow is judged on magnitude so negative results share the same limit
  always_comb begin
    w_abs    = w_wide[W2-1] ? -w_wide : w_wide;
    o_ovf    = $unsigned(w_abs) > MAX_W;
    o_result = w_wide[VAL_W:0];
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator key-entry FSM: turns decoded key strobes into operands,
// operators and results, and drives the display value and flags.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int VAL_W = VAL_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_press,
  input  logic             i_is_num,
  input  logic             i_is_op,
  input  logic             i_is_eq,
  input  logic [3:0]       i_num_val,
  input  logic [1:0]       i_op_val,
  output logic [VAL_W-1:0] o_disp_mag,
  output logic             o_disp_neg,
  output logic             o_err,
  output logic [2:0]       o_state,
  output logic [1:0]       o_op_pending,
  output logic             o_evt_ack
);

  localparam int MAXV_L = calc_maxv(NDIG);
  localparam int CNT_W  = $clog2(NDIG + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NDIG);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                  r_state, w_state_nxt;
  logic signed [VAL_W:0]   r_a, w_a_nxt;
  logic        [VAL_W-1:0] r_b, w_b_nxt;
  op_e                     r_op, w_op_nxt;
  logic        [CNT_W-1:0] r_cnt_a, w_cnt_a_nxt;
  logic        [CNT_W-1:0] r_cnt_b, w_cnt_b_nxt;
  logic                    r_btn_q;
  logic                    r_ack, w_ack_nxt;

  logic                    w_evt;
  logic                    w_key_num, w_key_op, w_key_eq;
  op_e                     w_op_in;
  logic        [VAL_W-1:0] w_digit;
  logic        [VAL_W-1:0] w_a_app;
  logic        [VAL_W-1:0] w_b_app;
  logic signed [VAL_W:0]   w_alu_res;
  logic                    w_alu_ovf;
  logic signed [VAL_W:0]   w_a_abs;

  // A key press is one event on its rising edge; simultaneous key classes
  // resolve as digit over operator over equals
  assign w_evt     = i_btn_press & ~r_btn_q;
  assign w_key_num = i_is_num;
  assign w_key_op  = ~i_is_num & i_is_op;
  assign w_key_eq  = ~i_is_num & ~i_is_op & i_is_eq;
  assign w_op_in   = op_e'(i_op_val);
  assign w_digit   = VAL_W'(i_num_val);

  // A never holds a negative value while digits are being appended to it
  assign w_a_app = r_a[VAL_W-1:0] * VAL_W'(10) + w_digit;
  assign w_b_app = r_b * VAL_W'(10) + w_digit;

  calc_alu #(
    .VAL_W  (VAL_W),
    .MAX_VAL(MAXV_L)
  ) u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_op),
    .o_result(w_alu_res),
    .o_ovf   (w_alu_ovf)
  );

  // State register and operand storage, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_NONE;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_btn_q <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
      r_btn_q <= i_btn_press;
      r_ack   <= w_ack_nxt;
    end
  end

  // Next-state logic: only an event cycle can change anything, and only
  // keys that actually do something raise the acknowledge
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_ack_nxt   = 1'b0;
    if (w_evt) begin
      case (r_state)
        S_A: begin
          if (w_key_num) begin
            if (r_cnt_a < CNT_MAX) begin
              w_a_nxt     = signed'({1'b0, w_a_app});
              w_cnt_a_nxt = r_cnt_a + CNT_ONE;
              w_ack_nxt   = 1'b1;
            end
          end else if (w_key_op) begin
            w_op_nxt    = w_op_in;
            w_state_nxt = S_OP;
            w_ack_nxt   = 1'b1;
          end
        end
        S_OP: begin
          if (w_key_num) begin
            w_b_nxt     = w_digit;
            w_cnt_b_nxt = CNT_ONE;
            w_state_nxt = S_B;
            w_ack_nxt   = 1'b1;
          end else if (w_key_op) begin
            w_op_nxt  = w_op_in;
            w_ack_nxt = 1'b1;
          end
        end
        S_B: begin
          if (w_key_num) begin
            if (r_cnt_b < CNT_MAX) begin
              w_b_nxt     = w_b_app;
              w_cnt_b_nxt = r_cnt_b + CNT_ONE;
              w_ack_nxt   = 1'b1;
            end
          end else if (w_key_op || w_key_eq) begin
            w_ack_nxt   = 1'b1;
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            if (w_alu_ovf) begin
              w_a_nxt     = '0;
              w_op_nxt    = OP_NONE;
              w_cnt_a_nxt = '0;
              w_state_nxt = S_ERR;
            end else begin
              w_a_nxt = w_alu_res;
              if (w_key_op) begin
                w_op_nxt    = w_op_in;
                w_state_nxt = S_OP;
              end else begin
                w_state_nxt = S_RES;
              end
            end
          end
        end
        S_RES: begin
          if (w_key_num) begin
            w_a_nxt     = signed'({1'b0, w_digit});
            w_cnt_a_nxt = CNT_ONE;
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            w_op_nxt    = OP_NONE;
            w_state_nxt = S_A;
            w_ack_nxt   = 1'b1;
          end else if (w_key_op) begin
            w_op_nxt    = w_op_in;
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            w_state_nxt = S_OP;
            w_ack_nxt   = 1'b1;
          end
        end
        S_ERR: begin
          if (w_key_num || w_key_op || w_key_eq) begin
            w_a_nxt     = w_key_num ? signed'({1'b0, w_digit}) : '0;
            w_cnt_a_nxt = w_key_num ? CNT_ONE : '0;
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            w_op_nxt    = OP_NONE;
            w_state_nxt = S_A;
            w_ack_nxt   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_A;
        end
      endcase
    end
  end

  // Display mapping: the operand being typed, or the accumulated value
  always_comb begin
    w_a_abs      = r_a[VAL_W] ? -r_a : r_a;
    o_disp_mag   = '0;
    o_disp_neg   = 1'b0;
    o_err        = 1'b0;
    o_op_pending = OP_NONE;
    case (r_state)
      S_A, S_RES: begin
        o_disp_mag = w_a_abs[VAL_W-1:0];
        o_disp_neg = r_a[VAL_W];
      end
      S_OP: begin
        o_disp_mag   = w_a_abs[VAL_W-1:0];
        o_disp_neg   = r_a[VAL_W];
        o_op_pending = r_op;
      end
      S_B: begin
        o_disp_mag   = r_b;
        o_op_pending = r_op;
      end
      S_ERR: begin
        o_err = 1'b1;
      end
      default: begin
        o_err = 1'b0;
      end
    endcase
  end

  assign o_state   = r_state;
  assign o_evt_ack = r_ack;

endmodule
